// File: rtl/request_unit_mc_if.sv
// request_unit_mc_if
//  Bundle between the datapath/control side (master) and the multi-channel
//  data-memory request unit (slave).
//  master drives: ihit, dhit, halt, ch_ren, ch_wen, ch_addr, ch_wdata
//  slave drives : dMemREN, dMemWEN, dMemAddr, dMemStore, grant, ch_done,
//                 busy, timeout_err, overrun_err
interface request_unit_mc_if #(
   parameter int NCH = 2,
   parameter int AW  = 32,
   parameter int DW  = 32
);
   logic              ihit;
   logic              dhit;
   logic              halt;
   logic [NCH-1:0]    ch_ren;
   logic [NCH-1:0]    ch_wen;
   logic [NCH*AW-1:0] ch_addr;
   logic [NCH*DW-1:0] ch_wdata;
   logic              dMemREN;
   logic              dMemWEN;
   logic [AW-1:0]     dMemAddr;
   logic [DW-1:0]     dMemStore;
   logic [NCH-1:0]    grant;
   logic [NCH-1:0]    ch_done;
   logic              busy;
   logic              timeout_err;
   logic              overrun_err;

   modport master (
      output ihit, dhit, halt, ch_ren, ch_wen, ch_addr, ch_wdata,
      input  dMemREN, dMemWEN, dMemAddr, dMemStore, grant, ch_done,
             busy, timeout_err, overrun_err
   );

   modport slave (
      input  ihit, dhit, halt, ch_ren, ch_wen, ch_addr, ch_wdata,
      output dMemREN, dMemWEN, dMemAddr, dMemStore, grant, ch_done,
             busy, timeout_err, overrun_err
   );
endinterface

// File: rtl/request_unit_mc.sv
// request_unit_mc
//  Multi-channel data-memory request unit. Each channel latches a REN/WEN
//  request on ihit and holds it until served; one request at a time is
//  granted onto the dMem port and held until dhit. halt flushes everything
//  except the sticky error flags; a watchdog aborts a grant that never
//  sees dhit.
//  Ports: CLK, nRST (async, active low), bus (request_unit_mc_if.slave).

// Per-channel request holder: pending flag plus latched payload.
module request_unit_mc_ch #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          CLK,
   input  logic          nRST,
   input  logic          halt,
   input  logic          req,       // ihit with REN or WEN on this channel
   input  logic          wen,
   input  logic          done_now,  // granted and dhit this cycle
   input  logic          abort,     // watchdog expiry on this channel
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic          pending,
   output logic          wr,
   output logic [AW-1:0] addr_q,
   output logic [DW-1:0] wdata_q,
   output logic          overrun
);
   // A request that lands on a still-pending slot is dropped; completing
   // this cycle frees the slot so the new request is taken instead.
   assign overrun = req & pending & ~done_now & ~halt;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         pending <= 1'b0;
         wr      <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (halt) begin
         pending <= 1'b0;
      end else if (req && (!pending || done_now)) begin
         pending <= 1'b1;
         wr      <= wen;
         addr_q  <= addr;
         wdata_q <= wdata;
      end else if (done_now || abort) begin
         pending <= 1'b0;
      end
   end
endmodule

module request_unit_mc #(
   parameter int NCH     = 2,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255,
   parameter int RR      = 1
) (
   input logic              CLK,
   input logic              nRST,
   request_unit_mc_if.slave bus
);
   localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t         state;
   logic [NCH-1:0] grant_q, done_q;
   logic [NCH-1:0] pending, wr, ovr, arb;
   logic [PW-1:0]  ptr, arb_idx, ptr_nxt;
   logic [TW-1:0]  wdog;
   logic           tmo_q, ovr_q;
   logic           active, wdog_max;
   logic [AW-1:0]  addr_q  [NCH];
   logic [DW-1:0]  wdata_q [NCH];
   logic [AW-1:0]  addr_mux;
   logic [DW-1:0]  wdata_mux;

   assign active   = (state == ACTIVE);
   assign wdog_max = (wdog == TW'(TIMEOUT - 1));

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      request_unit_mc_ch #(.AW(AW), .DW(DW)) u_ch (
         .CLK      (CLK),
         .nRST     (nRST),
         .halt     (bus.halt),
         .req      (bus.ihit & (bus.ch_ren[i] | bus.ch_wen[i])),
         .wen      (bus.ch_wen[i]),
         .done_now (active & bus.dhit & grant_q[i]),
         .abort    (active & ~bus.dhit & wdog_max & grant_q[i]),
         .addr     (bus.ch_addr[i*AW +: AW]),
         .wdata    (bus.ch_wdata[i*DW +: DW]),
         .pending  (pending[i]),
         .wr       (wr[i]),
         .addr_q   (addr_q[i]),
         .wdata_q  (wdata_q[i]),
         .overrun  (ovr[i])
      );
   end

   // Arbiter: scan starting at ptr (round-robin) or at 0 (fixed priority).
   always_comb begin
      int  idx;
      logic found;
      arb     = '0;
      arb_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < NCH; k++) begin
         idx = (RR != 0) ? int'(ptr) + k : k;
         if (idx >= NCH) idx = idx - NCH;
         if (!found && pending[idx]) begin
            found       = 1'b1;
            arb[idx]    = 1'b1;
            arb_idx     = PW'(idx);
         end
      end
   end

   assign ptr_nxt = (arb_idx == PW'(NCH - 1)) ? '0 : arb_idx + PW'(1);

   // grant_q is zero outside ACTIVE, so the OR-mux yields 0 when idle.
   always_comb begin
      addr_mux  = '0;
      wdata_mux = '0;
      for (int i = 0; i < NCH; i++) begin
         if (grant_q[i]) begin
            addr_mux  = addr_mux  | addr_q[i];
            wdata_mux = wdata_mux | wdata_q[i];
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state   <= IDLE;
         grant_q <= '0;
         done_q  <= '0;
         wdog    <= '0;
         ptr     <= '0;
         tmo_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else if (bus.halt) begin
         state   <= IDLE;
         grant_q <= '0;
         done_q  <= '0;
         wdog    <= '0;
      end else begin
         done_q <= '0;
         if (|ovr) ovr_q <= 1'b1;
         case (state)
            IDLE: begin
               if (|pending) begin
                  state   <= ACTIVE;
                  grant_q <= arb;
                  wdog    <= '0;
                  if (RR != 0) ptr <= ptr_nxt;
               end
            end
            ACTIVE: begin
               if (bus.dhit) begin
                  done_q  <= grant_q;
                  grant_q <= '0;
                  state   <= IDLE;
               end else if (wdog_max) begin
                  tmo_q   <= 1'b1;
                  grant_q <= '0;
                  state   <= IDLE;
               end else begin
                  wdog <= wdog + TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.dMemREN     = |(grant_q & ~wr);
   assign bus.dMemWEN     = |(grant_q & wr);
   assign bus.dMemAddr    = addr_mux;
   assign bus.dMemStore   = wdata_mux;
   assign bus.grant       = grant_q;
   assign bus.ch_done     = done_q;
   assign bus.busy        = (|pending) | active;
   assign bus.timeout_err = tmo_q;
   assign bus.overrun_err = ovr_q;
endmodule

// File: tb/tb_request_unit_mc.sv
// tb_request_unit_mc
//  Two instances: dut_a (fixed priority, TIMEOUT=4) and dut_b (round-robin).
//  Each grant is checked against an expected-transaction queue and each
//  ch_done pulse against an expected-completion queue by negedge monitors.
module tb_request_unit_mc;
   logic clk = 1'b0;
   logic nrst;
   always #5 clk = ~clk;

   request_unit_mc_if #(.NCH(2), .AW(32), .DW(32)) ifa ();
   request_unit_mc_if #(.NCH(2), .AW(32), .DW(32)) ifb ();

   request_unit_mc #(.NCH(2), .AW(32), .DW(32), .TIMEOUT(4), .RR(0)) dut_a (
      .CLK(clk), .nRST(nrst), .bus(ifa));
   request_unit_mc #(.NCH(2), .AW(32), .DW(32), .TIMEOUT(255), .RR(1)) dut_b (
      .CLK(clk), .nRST(nrst), .bus(ifb));

   int n_cmp = 0;
   int n_bad = 0;

   logic [67:0] exp_a[$], exp_b[$];
   logic [1:0]  done_a[$], done_b[$];
   logic [1:0]  prev_ga = '0, prev_gb = '0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // {grant, REN, WEN, addr, store}
   function automatic logic [67:0] mk(input int ch, input bit w,
                                      input logic [31:0] a, input logic [31:0] d);
      logic [1:0] g;
      g = 2'b00;
      g[ch] = 1'b1;
      return {g, ~w, w, a, d};
   endfunction

   always @(negedge clk) begin
      if (nrst) begin
         if (ifa.grant != 2'b00 && prev_ga == 2'b00) begin
            if (exp_a.size() == 0) chk("a_unexpected_grant", {ifa.grant}, 0);
            else chk("a_txn", {ifa.grant, ifa.dMemREN, ifa.dMemWEN, ifa.dMemAddr, ifa.dMemStore},
                     exp_a.pop_front());
         end
         if (ifa.ch_done != 2'b00) begin
            if (done_a.size() == 0) chk("a_unexpected_done", {ifa.ch_done}, 0);
            else chk("a_done", {ifa.ch_done}, {done_a.pop_front()});
         end
      end
      prev_ga = ifa.grant;
   end

   always @(negedge clk) begin
      if (nrst) begin
         if (ifb.grant != 2'b00 && prev_gb == 2'b00) begin
            if (exp_b.size() == 0) chk("b_unexpected_grant", {ifb.grant}, 0);
            else chk("b_txn", {ifb.grant, ifb.dMemREN, ifb.dMemWEN, ifb.dMemAddr, ifb.dMemStore},
                     exp_b.pop_front());
         end
         if (ifb.ch_done != 2'b00) begin
            if (done_b.size() == 0) chk("b_unexpected_done", {ifb.ch_done}, 0);
            else chk("b_done", {ifb.ch_done}, {done_b.pop_front()});
         end
      end
      prev_gb = ifb.grant;
   end

   function automatic logic en(input int d);
      return (d == 0) ? (ifa.dMemREN | ifa.dMemWEN) : (ifb.dMemREN | ifb.dMemWEN);
   endfunction

   task automatic set_dhit(input int d, input logic v);
      if (d == 0) ifa.dhit = v; else ifb.dhit = v;
   endtask

   // Called at a negedge; pulses ihit for one cycle, returns at a negedge.
   task automatic issue(input int d, input logic [1:0] ren, input logic [1:0] wen,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] w0, input logic [31:0] w1);
      if (d == 0) begin
         ifa.ch_ren = ren; ifa.ch_wen = wen; ifa.ch_addr = {a1, a0};
         ifa.ch_wdata = {w1, w0}; ifa.ihit = 1'b1;
      end else begin
         ifb.ch_ren = ren; ifb.ch_wen = wen; ifb.ch_addr = {a1, a0};
         ifb.ch_wdata = {w1, w0}; ifb.ihit = 1'b1;
      end
      @(negedge clk);
      if (d == 0) begin ifa.ihit = 1'b0; ifa.ch_ren = '0; ifa.ch_wen = '0; end
      else        begin ifb.ihit = 1'b0; ifb.ch_ren = '0; ifb.ch_wen = '0; end
   endtask

   task automatic wait_en(input int d);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (en(d)) return;
      end
      chk("wait_en_timeout", 0, 1);
   endtask

   // Wait for a grant, hold dhit low for cyc-1 cycles, assert dhit in cycle cyc.
   task automatic serve(input int d, input int cyc, output int cnt);
      cnt = 0;
      wait_en(d);
      if (en(d)) cnt = 1;
      repeat (cyc - 1) begin
         @(negedge clk);
         if (en(d)) cnt++;
      end
      set_dhit(d, 1'b1);
      @(negedge clk);
      set_dhit(d, 1'b0);
   endtask

   initial begin
      int c;
      nrst = 1'b0;
      ifa.ihit = 0; ifa.dhit = 0; ifa.halt = 0; ifa.ch_ren = 0; ifa.ch_wen = 0;
      ifa.ch_addr = 0; ifa.ch_wdata = 0;
      ifb.ihit = 0; ifb.dhit = 0; ifb.halt = 0; ifb.ch_ren = 0; ifb.ch_wen = 0;
      ifb.ch_addr = 0; ifb.ch_wdata = 0;
      repeat (2) @(negedge clk);
      chk("reset_state", {ifa.dMemREN, ifa.dMemWEN, ifa.dMemAddr, ifa.dMemStore, ifa.grant,
                          ifa.ch_done, ifa.busy, ifa.timeout_err, ifa.overrun_err}, 0);
      nrst = 1'b1;
      @(negedge clk);

      // Round-robin: ch0 alone moves the pointer to 1, then both -> 1 first.
      exp_b.push_back(mk(0, 0, 32'hA0, 0)); done_b.push_back(2'b01);
      issue(1, 2'b01, 2'b00, 32'hA0, 0, 0, 0);
      serve(1, 1, c);
      exp_b.push_back(mk(1, 0, 32'hB1, 0)); done_b.push_back(2'b10);
      exp_b.push_back(mk(0, 0, 32'hB0, 0)); done_b.push_back(2'b01);
      issue(1, 2'b11, 2'b00, 32'hB0, 32'hB1, 0, 0);
      serve(1, 1, c);
      serve(1, 2, c);
      exp_b.push_back(mk(1, 1, 32'hC1, 32'h11)); done_b.push_back(2'b10);
      exp_b.push_back(mk(0, 1, 32'hC0, 32'h22)); done_b.push_back(2'b01);
      issue(1, 2'b00, 2'b11, 32'hC0, 32'hC1, 32'h22, 32'h11);
      serve(1, 1, c);
      serve(1, 1, c);
      chk("b_idle_after_rr", {ifb.busy}, 0);

      // Single read, dhit in third ACTIVE cycle.
      exp_a.push_back(mk(0, 0, 32'h100, 0)); done_a.push_back(2'b01);
      issue(0, 2'b01, 2'b00, 32'h100, 0, 0, 0);
      serve(0, 3, c);
      chk("single_en_cycles", c, 3);
      @(negedge clk);
      chk("single_busy_after", {ifa.busy}, 0);

      // Both channels, fixed priority: ch0 first, one IDLE cycle, then ch1 write.
      exp_a.push_back(mk(0, 0, 32'h10, 0));         done_a.push_back(2'b01);
      exp_a.push_back(mk(1, 1, 32'h20, 32'hDEAD));  done_a.push_back(2'b10);
      issue(0, 2'b01, 2'b10, 32'h10, 32'h20, 0, 32'hDEAD);
      serve(0, 2, c);
      chk("gap_idle_en", {en(0), ifa.busy}, 2'b01);
      serve(0, 1, c);

      // dhit and new ihit on the granted channel in the same cycle.
      exp_a.push_back(mk(0, 0, 32'h700, 0));        done_a.push_back(2'b01);
      exp_a.push_back(mk(0, 1, 32'h710, 32'hBEEF)); done_a.push_back(2'b01);
      issue(0, 2'b01, 2'b00, 32'h700, 0, 0, 0);
      wait_en(0);
      ifa.dhit = 1'b1; ifa.ch_wen = 2'b01; ifa.ch_addr = {32'h0, 32'h710};
      ifa.ch_wdata = {32'h0, 32'hBEEF}; ifa.ihit = 1'b1;
      @(negedge clk);
      ifa.dhit = 1'b0; ifa.ihit = 1'b0; ifa.ch_wen = 2'b00;
      chk("recapture_no_overrun", {ifa.overrun_err, ifa.busy}, 2'b01);
      serve(0, 1, c);

      // Watchdog: ch0 never answered, aborted after 4 ACTIVE cycles, ch1 served next.
      exp_a.push_back(mk(0, 0, 32'h300, 0));
      exp_a.push_back(mk(1, 0, 32'h400, 0)); done_a.push_back(2'b10);
      issue(0, 2'b11, 2'b00, 32'h300, 32'h400, 0, 0);
      wait_en(0);
      repeat (3) @(negedge clk);
      chk("wdog_4th_cycle", {ifa.timeout_err, en(0)}, 2'b01);
      @(negedge clk);
      chk("wdog_abort", {ifa.timeout_err, en(0), ifa.busy, ifa.ch_done}, 5'b10100);
      serve(0, 1, c);

      // Overrun: second ihit on ch1 while still pending, original address issued.
      exp_a.push_back(mk(1, 0, 32'h500, 0)); done_a.push_back(2'b10);
      chk("overrun_before", {ifa.overrun_err}, 0);
      issue(0, 2'b10, 2'b00, 0, 32'h500, 0, 0);
      issue(0, 2'b10, 2'b00, 0, 32'h600, 0, 0);
      chk("overrun_set", {ifa.overrun_err}, 1);
      serve(0, 1, c);

      // halt mid-ACTIVE.
      exp_a.push_back(mk(0, 0, 32'h800, 0));
      issue(0, 2'b01, 2'b00, 32'h800, 0, 0, 0);
      wait_en(0);
      ifa.halt = 1'b1;
      @(negedge clk);
      ifa.halt = 1'b0;
      chk("halt_flush", {ifa.dMemREN, ifa.dMemWEN, ifa.grant, ifa.busy,
                         ifa.timeout_err, ifa.overrun_err}, 7'b0000011);
      @(negedge clk);
      chk("halt_stays_idle", {en(0), ifa.busy}, 0);

      // Async reset mid-ACTIVE.
      exp_a.push_back(mk(1, 1, 32'h900, 32'h55));
      issue(0, 2'b00, 2'b10, 0, 32'h900, 0, 32'h55);
      wait_en(0);
      #2 nrst = 1'b0;
      #1 chk("async_reset", {ifa.dMemREN, ifa.dMemWEN, ifa.dMemAddr, ifa.dMemStore, ifa.grant,
                             ifa.ch_done, ifa.busy, ifa.timeout_err, ifa.overrun_err}, 0);
      @(negedge clk);
      nrst = 1'b1;
      repeat (2) @(negedge clk);

      chk("a_txn_queue_empty",  exp_a.size(),  0);
      chk("a_done_queue_empty", done_a.size(), 0);
      chk("b_txn_queue_empty",  exp_b.size(),  0);
      chk("b_done_queue_empty", done_b.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
